// File: rtl/mux_stream_sel.sv
// rtl/mux_stream_sel.sv - registered NCH:1 stream mux, fixed-select or round-robin grant
// Optional illegal-select sticky flag built only when MUX_SEL_CHECK_EN is defined.
module mux_stream_sel #(
    parameter int NCH  = 3,
    parameter int W    = 16,
    parameter int SELW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH*W-1:0]   in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch,
    output logic               sel_err
);

    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] grant;
    logic            grant_ok;
    logic            sel_legal;
    logic            load_en;
    logic            xfer;
    logic [SELW:0]   idx;
    logic [W-1:0]    grant_data;

    assign sel_legal = ({1'b0, sel} < (SELW+1)'(NCH));
    assign load_en   = !out_valid || out_ready;

    // Reverse search so the lowest offset from rr_ptr wins.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        idx      = '0;
        if (!mode) begin
            if (sel_legal) begin
                grant    = sel;
                grant_ok = 1'b1;
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr} + (SELW+1)'(k);
                if (idx >= (SELW+1)'(NCH)) begin
                    idx = idx - (SELW+1)'(NCH);
                end
                if (in_valid[idx[SELW-1:0]]) begin
                    grant    = idx[SELW-1:0];
                    grant_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = !reset && load_en && grant_ok && (grant == SELW'(i));
        end
    end

    assign grant_data = in_data[int'(grant)*W +: W];
    assign xfer       = load_en && grant_ok && in_valid[grant];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            if (mode) begin
                rr_ptr <= (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_SEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (!mode && !sel_legal) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_stream_sel.sv
// tb/tb_mux_stream_sel.sv - vector table, corner sequences and randomized model check
module tb_mux_stream_sel;
    localparam int NCH  = 3;
    localparam int W    = 16;
    localparam int SELW = 2;
`ifdef MUX_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NCH*W-1:0]   in_data;
    logic [NCH-1:0]     in_valid;
    logic [NCH-1:0]     in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_ch;
    logic               sel_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] chd [NCH];

    // Reference state: one held beat plus the round-robin starting point.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    bit           m_err;

    mux_stream_sel #(.NCH(NCH), .W(W), .SELW(SELW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       m;
        int       s;
        bit [2:0] v;
        bit       ordy;
        bit [2:0] exp_rdy;
        bit       exp_ov;
        int       exp_ch;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_grant(input bit m, input int s, input bit [2:0] v,
                               output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
        if (!m) begin
            ok = (s < NCH);
            g  = s;
        end else begin
            for (int k = 0; k < NCH && !ok; k++) begin
                if (v[(m_ptr + k) % NCH]) begin
                    ok = 1'b1;
                    g  = (m_ptr + k) % NCH;
                end
            end
        end
    endtask

    task automatic cycle(input bit m, input int s, input bit [2:0] v,
                         input bit ordy, input bit rst);
        bit       ok;
        int       g;
        bit       load;
        bit [2:0] er;
        mode      = m;
        sel       = SELW'(s);
        in_valid  = v;
        out_ready = ordy;
        reset     = rst;
        for (int i = 0; i < NCH; i++) in_data[i*W +: W] = chd[i];
        #1;
        model_grant(m, s, v, ok, g);
        load = !m_valid || ordy;
        er   = (!rst && load && ok) ? 3'(1 << g) : 3'b000;
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_err = 0;
        end else begin
            if (load && ok && v[g]) begin
                m_valid = 1; m_data = chd[g]; m_ch = g;
                if (m) m_ptr = (g + 1) % NCH;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (CHK && !m && s >= NCH) m_err = 1;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
        chk("sel_err",   32'(sel_err),   32'(m_err));
    endtask

    vec_t tbl [15];

    initial begin
        chd[0] = 16'h1111; chd[1] = 16'hBEEF; chd[2] = 16'h2222;
        m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_err = 0;

        tbl[0]  = '{0, 1, 3'b111, 1, 3'b010, 1, 1};
        tbl[1]  = '{1, 0, 3'b111, 1, 3'b001, 1, 0};
        tbl[2]  = '{1, 0, 3'b111, 1, 3'b010, 1, 1};
        tbl[3]  = '{1, 0, 3'b111, 1, 3'b100, 1, 2};
        tbl[4]  = '{1, 0, 3'b111, 1, 3'b001, 1, 0};
        tbl[5]  = '{1, 0, 3'b111, 1, 3'b010, 1, 1};
        tbl[6]  = '{1, 0, 3'b101, 1, 3'b100, 1, 2};
        tbl[7]  = '{1, 0, 3'b101, 1, 3'b001, 1, 0};
        tbl[8]  = '{1, 0, 3'b101, 1, 3'b100, 1, 2};
        tbl[9]  = '{1, 0, 3'b101, 1, 3'b001, 1, 0};
        tbl[10] = '{0, 3, 3'b111, 1, 3'b000, 0, 0};
        tbl[11] = '{0, 2, 3'b111, 1, 3'b100, 1, 2};
        tbl[12] = '{1, 0, 3'b111, 1, 3'b010, 1, 1};
        tbl[13] = '{0, 2, 3'b000, 1, 3'b100, 0, 1};
        tbl[14] = '{1, 0, 3'b000, 1, 3'b000, 0, 1};

        // Two reset cycles leave everything cleared.
        cycle(0, 0, 3'b000, 1, 1);
        cycle(0, 0, 3'b000, 1, 1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);

        for (int i = 0; i < 15; i++) begin
            mode = tbl[i].m; sel = SELW'(tbl[i].s); in_valid = tbl[i].v;
            out_ready = tbl[i].ordy; reset = 1'b0;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            cycle(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].ordy, 0);
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_ch", i), 32'(out_ch), 32'(tbl[i].exp_ch));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(chd[tbl[i].exp_ch]));
            chk($sformatf("vec%0d_err", i), 32'(sel_err), 32'((CHK && i >= 10) ? 1 : 0));
        end

        // Backpressure: beat from ch0 held for three cycles while sel points at ch2.
        cycle(0, 0, 3'b111, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 2, 3'b111, 0, 0);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_ch", 32'(out_ch), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h1111);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b100);
        cycle(0, 2, 3'b111, 1, 0);
        chk("bp_new_ch", 32'(out_ch), 32'd2);
        chk("bp_new_data", 32'(out_data), 32'h2222);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) chd[i] = W'($urandom);
            cycle(1'($urandom), int'($urandom_range(0, 3)), 3'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
        end

        // Reset with a held beat: everything clears and RR restarts at ch0.
        cycle(1, 0, 3'b111, 0, 0);
        cycle(0, 1, 3'b111, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        mode = 0; sel = 1; in_valid = 3'b111; out_ready = 1; reset = 1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        cycle(0, 1, 3'b111, 1, 1);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_data", 32'(out_data), 32'd0);
        chk("rst2_ch", 32'(out_ch), 32'd0);
        chk("rst2_err", 32'(sel_err), 32'd0);
        cycle(1, 0, 3'b111, 1, 0);
        chk("rst2_rr_first", 32'(out_ch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
